ahb_img_buffer_slave: RTL and testbench

// AHB-Lite slave behind the Sobel top's address decoder (selected by HSEL_2).
// - Accepts raster-order pixel writes; buffers two lines plus a 3x3 shift window.
// - Presents each complete 3x3 neighbourhood to the convolution stage over a valid/ready handshake.

---
 rtl/ahb_img_buffer_slave.sv | 215 +++++++++++++++++++++
 tb/tb_ahb_img_buffer_slave.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_img_buffer_slave.sv
// ahb_img_buffer_slave
// AHB-Lite slave that collects raster-order pixels into two line buffers plus a
// two-column history, and hands every complete 3x3 neighbourhood to the
// convolution stage over a valid/ready handshake.
// Optional feature macro: IMGBUF_STALL_EN
//   defined   : a window-producing pixel is held off with wait states while the
//               previous window is still unaccepted.
//   undefined : HREADYOUT stays 1; an unaccepted window is overwritten and the
//               sticky overflow flag is set.

module ahb_img_buffer_slave #(
   parameter int IMG_WIDTH  = 16,
   parameter int IMG_HEIGHT = 16,
   parameter int PIX_W      = 8
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [31:0]          HWDATA,
   input  logic                 HREADY,
   output logic [31:0]          HRDATA,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [9*PIX_W-1:0]   win_pix,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic                 frame_done
);

   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int CB = 3 * PIX_W;
   localparam logic [4:0] LAST_COL = 5'(IMG_WIDTH - 1);
   localparam logic [4:0] LAST_ROW = 5'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [4:0] col;
   logic [4:0] row;
   logic       overflow;

   logic       dp_valid;
   logic       dp_write;
   logic [1:0] dp_addr;

   // Line buffers: line_top holds the row two above the current one,
   // line_mid the row directly above.
   logic [PIX_W-1:0] line_top [IMG_WIDTH];
   logic [PIX_W-1:0] line_mid [IMG_WIDTH];

   // Two most recent columns, each packed {top, mid, bottom}.
   logic [CB-1:0] hist_l;
   logic [CB-1:0] hist_r;

   logic [AW-1:0]      col_idx;
   logic [PIX_W-1:0]   new_pix;
   logic [CB-1:0]      new_col;
   logic [9*PIX_W-1:0] new_window;
   logic               frame_active;
   logic               pix_req;
   logic               win_cand;
   logic               stall;
   logic               pix_wr;
   logic               win_new;
   logic               ctrl_start;
   logic               at_last_col;
   logic               at_last_pix;
   logic [1:0]         state_bits;
   logic [31:0]        status_word;
   logic               unused_bits;

   assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:PIX_W]};

   assign col_idx      = col[AW-1:0];
   assign new_pix      = HWDATA[PIX_W-1:0];
   assign new_col      = {line_top[col_idx], line_mid[col_idx], new_pix};
   assign frame_active = (state == FILL) || (state == STREAM);
   assign pix_req      = dp_valid & dp_write & (dp_addr == 2'd0) & frame_active;
   assign win_cand     = pix_req & (row >= 5'd2) & (col >= 5'd2);
   assign at_last_col  = (col == LAST_COL);
   assign at_last_pix  = at_last_col & (row == LAST_ROW);

`ifdef IMGBUF_STALL_EN
   assign stall = win_cand & win_valid & ~win_ready;
`else
   assign stall = 1'b0;
`endif

   assign pix_wr     = pix_req & ~stall;
   assign win_new    = win_cand & ~stall;
   assign ctrl_start = dp_valid & ~stall & dp_write & (dp_addr == 2'd1) & HWDATA[0];

   // Row-major window, top-left pixel in the MSBs: oldest column on the left.
   assign new_window = {hist_l[CB-1 -: PIX_W], hist_r[CB-1 -: PIX_W], new_col[CB-1 -: PIX_W],
                        hist_l[2*PIX_W-1 -: PIX_W], hist_r[2*PIX_W-1 -: PIX_W], new_col[2*PIX_W-1 -: PIX_W],
                        hist_l[PIX_W-1:0], hist_r[PIX_W-1:0], new_col[PIX_W-1:0]};

   assign state_bits  = state;
   assign status_word = {19'b0, overflow, state_bits, row, col};

   assign HREADYOUT = ~stall;
   assign HRESP     = 1'b0;
   assign HRDATA    = (dp_valid & ~dp_write & (dp_addr == 2'd2)) ? status_word : 32'd0;

   // Capture the address phase; it is held while the bus is not ready so a
   // stalled data phase keeps its own transfer attributes.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= 2'd0;
      end else if (HREADY) begin
         dp_valid <= HSEL & HTRANS[1];
         dp_write <= HWRITE;
         dp_addr  <= HADDR[3:2];
      end
   end

   // Frame-sequencing state register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: frame_start always restarts filling, pixels advance it.
   always_comb begin
      state_next = state;
      if (ctrl_start) begin
         state_next = FILL;
      end else if (pix_wr) begin
         case (state)
            FILL:    if (at_last_col && (row == 5'd1)) state_next = STREAM;
            STREAM:  if (at_last_pix) state_next = DONE;
            default: state_next = state;
         endcase
      end
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         col <= 5'd0;
         row <= 5'd0;
      end else if (ctrl_start) begin
         col <= 5'd0;
         row <= 5'd0;
      end else if (pix_wr) begin
         if (at_last_col) begin
            col <= 5'd0;
            row <= row + 5'd1;
         end else begin
            col <= col + 5'd1;
         end
      end
   end

   // Line buffers age by one row at the current column; contents are not reset
   // because the first two rows of every frame rewrite them before use.
   always_ff @(posedge HCLK) begin
      if (pix_wr) begin
         line_top[col_idx] <= line_mid[col_idx];
         line_mid[col_idx] <= new_pix;
      end
   end

   // Column history feeding the left two columns of the next window.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hist_l <= '0;
         hist_r <= '0;
      end else if (pix_wr) begin
         hist_l <= hist_r;
         hist_r <= new_col;
      end
   end

   // Window handshake: load a new window, retire an accepted one, flag overwrites.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         win_pix    <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (ctrl_start) begin
            win_valid <= 1'b0;
            overflow  <= 1'b0;
         end else if (win_new) begin
            win_pix    <= new_window;
            win_valid  <= 1'b1;
            frame_done <= at_last_pix;
`ifndef IMGBUF_STALL_EN
            if (win_valid && !win_ready) overflow <= 1'b1;
`endif
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb_img_buffer_slave.sv
// tb_ahb_img_buffer_slave
// Self-checking bench for ahb_img_buffer_slave (default build, IMGBUF_STALL_EN
// undefined). A frame-level model keeps the whole image in an array and derives
// every window, status word and pulse from raster position arithmetic.

module tb_ahb_img_buffer_slave;

   localparam int W = 16;
   localparam int H = 16;

   logic        HCLK;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [71:0] win_pix;
   logic        win_valid;
   logic        win_ready;
   logic        frame_done;

   ahb_img_buffer_slave #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .win_pix(win_pix), .win_valid(win_valid),
      .win_ready(win_ready), .frame_done(frame_done)
   );

   // Clock generation.
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   int checks = 0;
   int errors = 0;

   // Frame-level reference model state.
   bit          m_started = 0;
   bit          m_active  = 0;
   int          m_idx     = 0;
   bit          m_ovf     = 0;
   bit          m_valid   = 0;
   bit          m_done    = 0;
   logic [71:0] m_pix     = '0;
   bit          m_dp_valid = 0;
   bit          m_dp_write = 0;
   logic [1:0]  m_dp_addr  = 2'd0;
   int          m_wins    = 0;
   logic [7:0]  img [W*H];
   int          m_r, m_c;
   bit          m_fresh;

   // Counters kept by the compare process.
   int rise_cnt = 0;
   int done_cnt = 0;
   bit prev_valid = 0;

   // Literal expectations posted by the stimulus process, checked by the compare process.
   string       lit_name [64];
   logic [71:0] lit_act  [64];
   logic [71:0] lit_exp  [64];
   int          lit_count = 0;
   int          lit_done  = 0;

   int ready_mode = 1;

   function automatic logic [71:0] window_at(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w = {w[63:0], img[(r - 2 + i) * W + (c - 2 + j)]};
      return w;
   endfunction

   function automatic logic [31:0] exp_status();
      int st;
      logic [4:0] rr;
      logic [4:0] cc;
      if (!m_started)     st = 0;
      else if (!m_active) st = 3;
      else if (m_idx < 2 * W) st = 1;
      else                st = 2;
      rr = 5'(m_idx / W);
      cc = 5'(m_idx % W);
      return {19'b0, m_ovf, 2'(st), rr, cc};
   endfunction

   function automatic logic [31:0] exp_rdata();
      if (m_dp_valid && !m_dp_write && (m_dp_addr == 2'd2)) return exp_status();
      return 32'd0;
   endfunction

   // Reference model: completes the outstanding data phase, then records the new address phase.
   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m_started = 0; m_active = 0; m_idx = 0; m_ovf = 0;
         m_valid = 0; m_done = 0; m_pix = '0;
         m_dp_valid = 0; m_dp_write = 0; m_dp_addr = 2'd0;
      end else begin
         m_fresh = 0;
         m_done  = 0;
         if (m_dp_valid && m_dp_write && (m_dp_addr == 2'd1) && HWDATA[0]) begin
            m_started = 1; m_active = 1; m_idx = 0; m_ovf = 0; m_valid = 0;
         end else begin
            if (m_dp_valid && m_dp_write && (m_dp_addr == 2'd0) && m_active) begin
               m_r = m_idx / W;
               m_c = m_idx % W;
               img[m_idx] = HWDATA[7:0];
               if (m_r >= 2 && m_c >= 2) begin
                  m_fresh = 1;
                  if (m_valid && !win_ready) m_ovf = 1;
                  m_pix = window_at(m_r, m_c);
                  m_wins++;
                  m_done = (m_idx == W * H - 1);
               end
               m_idx++;
               if (m_idx == W * H) m_active = 0;
            end
            if (m_fresh) m_valid = 1;
            else if (win_ready) m_valid = 0;
         end
         if (HREADY) begin
            m_dp_valid = HSEL && HTRANS[1];
            m_dp_write = HWRITE;
            m_dp_addr  = HADDR[3:2];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, DUT outputs against the model, then posted literals.
   always @(negedge HCLK) begin
      checkOutput("win_valid", 72'(win_valid), 72'(m_valid));
      checkOutput("win_pix", win_pix, m_pix);
      checkOutput("frame_done", 72'(frame_done), 72'(m_done));
      checkOutput("hreadyout", 72'(HREADYOUT), 72'd1);
      checkOutput("hresp", 72'(HRESP), 72'd0);
      checkOutput("hrdata", 72'(HRDATA), 72'(exp_rdata()));
      if (win_valid && !prev_valid) rise_cnt++;
      if (frame_done) done_cnt++;
      prev_valid = win_valid;
      while (lit_done < lit_count) begin
         checkOutput(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
         lit_done++;
      end
   end

   // win_ready source: held low, held high or randomised each cycle.
   initial begin
      win_ready = 1'b1;
      forever begin
         @(posedge HCLK);
         #2;
         case (ready_mode)
            0:       win_ready = 1'b0;
            1:       win_ready = 1'b1;
            default: win_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic expectLiteral(input string name, input logic [71:0] act, input logic [71:0] exp);
      lit_name[lit_count] = name;
      lit_act[lit_count]  = act;
      lit_exp[lit_count]  = exp;
      lit_count++;
   endtask

   // One non-pipelined transfer; returns the data-phase read value.
   task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [3:0] addr,
                                input logic write, input logic [31:0] data, output logic [31:0] rdata);
      @(posedge HCLK); #1;
      HSEL = sel; HTRANS = trans; HADDR = {28'h0, addr}; HWRITE = write;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = data;
      @(negedge HCLK);
      rdata = HRDATA;
      @(posedge HCLK); #1;
   endtask

   task automatic writePixel(input logic [7:0] p);
      logic [31:0] rd;
      applyStimulus(1'b1, 2'b10, 4'h0, 1'b1, {24'h0, p}, rd);
   endtask

   task automatic writeCtrl(input logic [31:0] v);
      logic [31:0] rd;
      applyStimulus(1'b1, 2'b10, 4'h4, 1'b1, v, rd);
   endtask

   task automatic readReg(input logic [3:0] addr, output logic [31:0] rd);
      applyStimulus(1'b1, 2'b10, addr, 1'b0, 32'h0, rd);
   endtask

   // Back-to-back pipelined pixel writes: NONSEQ then SEQ, one per cycle.
   task automatic burstFrame(input int n, input int mult);
      @(posedge HCLK); #1;
      HSEL = 1'b1; HWRITE = 1'b1; HADDR = 32'h0; HTRANS = 2'b10;
      for (int i = 0; i < n; i++) begin
         @(posedge HCLK); #1;
         HWDATA = 32'((i * mult) & 8'hFF);
         if (i == n - 1) begin
            HTRANS = 2'b00; HSEL = 1'b0;
         end else begin
            HTRANS = 2'b11;
         end
      end
      @(posedge HCLK); #1;
   endtask

   logic [31:0] rd;
   logic [71:0] first_win;
   bit          got_first;
   int          rise0, done0, wins0, first_k, pix_sent, choice;

   initial begin
      HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00;
      HWRITE = 1'b0; HWDATA = 32'h0; HREADY = 1'b1;
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      $display("[TB] pixel writes before any frame_start");
      for (int i = 0; i < 5; i++) writePixel(8'(i + 9));
      readReg(4'h8, rd);
      expectLiteral("idle_status", 72'(rd), 72'd0);
      expectLiteral("idle_no_window", 72'(win_valid), 72'd0);

      $display("[TB] reset in the middle of streaming");
      ready_mode = 0;
      writeCtrl(32'h1);
      for (int i = 0; i < 40; i++) writePixel(8'(i));
      @(posedge HCLK); #3;
      HRESETn = 1'b0;
      #1;
      expectLiteral("rst_win_valid", 72'(win_valid), 72'd0);
      expectLiteral("rst_win_pix", win_pix, 72'd0);
      expectLiteral("rst_frame_done", 72'(frame_done), 72'd0);
      expectLiteral("rst_hreadyout", 72'(HREADYOUT), 72'd1);
      expectLiteral("rst_hrdata", 72'(HRDATA), 72'd0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      ready_mode = 1;
      readReg(4'h8, rd);
      expectLiteral("rst_status", 72'(rd), 72'd0);

      $display("[TB] full ramp frame");
      rise0 = rise_cnt; done0 = done_cnt; wins0 = m_wins; got_first = 0;
      writeCtrl(32'h1);
      for (int i = 0; i < W * H; i++) begin
         writePixel(8'(i));
         if (win_valid && !got_first) begin
            first_win = win_pix;
            got_first = 1;
         end
      end
      repeat (3) @(posedge HCLK);
      #1;
      expectLiteral("ramp_first_window", first_win, 72'h000102101112202122);
      expectLiteral("ramp_window_rises", 72'(rise_cnt - rise0), 72'd196);
      expectLiteral("ramp_model_windows", 72'(m_wins - wins0), 72'd196);
      expectLiteral("ramp_frame_done", 72'(done_cnt - done0), 72'd1);

      $display("[TB] consumer stops after the first window");
      writeCtrl(32'h1);
      for (int i = 0; i < 35; i++) writePixel(8'(i * 5));
      ready_mode = 0;
      for (int i = 35; i < 40; i++) writePixel(8'(i * 5));
      readReg(4'h8, rd);
      expectLiteral("overflow_bit", 72'(rd[12]), 72'd1);
      ready_mode = 1;

      $display("[TB] abort after 40 pixels, then a fresh frame");
      writeCtrl(32'h1);
      for (int i = 0; i < 40; i++) writePixel(8'(255 - i));
      done0 = done_cnt;
      writeCtrl(32'h1);
      expectLiteral("abort_drops_valid", 72'(win_valid), 72'd0);
      first_k = 0;
      for (int k = 1; k <= 40; k++) begin
         writePixel(8'(k * 7));
         if (win_valid && first_k == 0) first_k = k;
      end
      expectLiteral("restart_first_window_pixel", 72'(first_k), 72'd35);
      expectLiteral("abort_no_frame_done", 72'(done_cnt - done0), 72'd0);

      $display("[TB] back-to-back SEQ frame");
      done0 = done_cnt;
      writeCtrl(32'h1);
      burstFrame(W * H, 3);
      repeat (3) @(posedge HCLK);
      #1;
      expectLiteral("burst_frame_done", 72'(done_cnt - done0), 72'd1);

      $display("[TB] randomised frame with random consumer");
      ready_mode = 2;
      writeCtrl(32'h1);
      pix_sent = 0;
      for (int it = 0; it < 3000 && pix_sent < W * H; it++) begin
         choice = $urandom_range(0, 19);
         if (choice < 14) begin
            writePixel(8'($urandom_range(0, 255)));
            pix_sent++;
         end else if (choice == 14) readReg(4'h8, rd);
         else if (choice == 15) readReg(4'hC, rd);
         else if (choice == 16) readReg(4'h0, rd);
         else if (choice == 17) applyStimulus(1'b1, 2'b10, 4'h8, 1'b1, $urandom, rd);
         else if (choice == 18) applyStimulus(1'b0, 2'b10, 4'h0, 1'b1, $urandom, rd);
         else applyStimulus(1'b1, 2'b01, 4'h0, 1'b1, $urandom, rd);
      end
      readReg(4'h8, rd);
      ready_mode = 1;
      repeat (4) @(posedge HCLK);

      @(negedge HCLK);
      @(negedge HCLK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
